// File: rtl/ps2_key_event_fifo_pkg.sv
// Shared constants and types for the PS/2 key-event path: prefix bytes,
// event word layout and the prefix-tracking state type.
package ps2_key_event_fifo_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL = 8'hF0;

    localparam int KEY_EV_EXT_BIT = 8;
    localparam int KEY_EV_REL_BIT = 9;

    typedef enum logic [1:0] {
        PFX_IDLE   = 2'd0,
        PFX_EXT    = 2'd1,
        PFX_REL    = 2'd2,
        PFX_EXTREL = 2'd3
    } ps2_pfx_state_t;

    // Packs a scancode and its prefix flags into one event word, upper bits zero.
    function automatic logic [WORD_SIZE-1:0] make_key_event(input logic ext,
                                                            input logic rel,
                                                            input logic [7:0] code);
        logic [WORD_SIZE-1:0] word;
        word                 = '0;
        word[7:0]            = code;
        word[KEY_EV_EXT_BIT] = ext;
        word[KEY_EV_REL_BIT] = rel;
        return word;
    endfunction

endpackage

// File: rtl/ps2_key_event_fifo_if.sv
// Bus between the PS/2 byte source / IO reader and the key-event FIFO.
// The master side drives bytes and read requests; the slave side is the FIFO.
interface ps2_key_event_fifo_if
    import ps2_key_event_fifo_pkg::*;
#(
    parameter int DEPTH = 16
);

    logic                   byte_valid;
    logic [7:0]             byte_data;
    logic                   rd_req;
    logic                   clr_overflow;
    logic [WORD_SIZE-1:0]   rd_data;
    logic                   rd_valid;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    modport master (
        output byte_valid, byte_data, rd_req, clr_overflow,
        input  rd_data, rd_valid, full, count, overflow
    );

    modport slave (
        input  byte_valid, byte_data, rd_req, clr_overflow,
        output rd_data, rd_valid, full, count, overflow
    );

endinterface

// File: rtl/ps2_key_event_fifo_fifo_sync.sv
// Generic synchronous FIFO with first-word-fall-through head output.
// A push while full is still accepted when a pop frees a slot in the same cycle.
module fifo_sync #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic                   dropped,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign dropped   = push && !do_push;
    assign count     = wr_ptr - rd_ptr;
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointers advance on accepted push/pop and wrap through the extra MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is written at the tail slot; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ps2_key_event_fifo.sv
// Folds PS/2 E0/F0 prefixes into single key-event words and buffers them
// in a small FIFO that the IO side drains one event per read request.
module ps2_key_event_fifo
    import ps2_key_event_fifo_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input logic                 clk,
    input logic                 rst,
    ps2_key_event_fifo_if.slave bus
);

    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

    ps2_pfx_state_t       state;
    ps2_pfx_state_t       state_next;
    logic [TW-1:0]        timer;
    logic                 timed_out;
    logic                 emit;
    logic                 emit_ext;
    logic                 emit_rel;
    logic [WORD_SIZE-1:0] emit_word;
    logic                 fifo_empty;
    logic                 fifo_dropped;

    assign timed_out = (state != PFX_IDLE) && !bus.byte_valid &&
                       (timer == TW'(PREFIX_TIMEOUT - 1));
    assign emit_word = make_key_event(emit_ext, emit_rel, bus.byte_data);

    // Prefix decoding: prefixes only move the state, any other byte emits an event.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_rel   = 1'b0;
        if (bus.byte_valid) begin
            case (state)
                PFX_IDLE: begin
                    if (bus.byte_data == PS2_PFX_EXT)      state_next = PFX_EXT;
                    else if (bus.byte_data == PS2_PFX_REL) state_next = PFX_REL;
                    else                                   emit = 1'b1;
                end
                PFX_EXT: begin
                    if (bus.byte_data == PS2_PFX_REL) state_next = PFX_EXTREL;
                    else if (bus.byte_data != PS2_PFX_EXT) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        state_next = PFX_IDLE;
                    end
                end
                PFX_REL: begin
                    if (bus.byte_data == PS2_PFX_EXT) state_next = PFX_EXTREL;
                    else if (bus.byte_data != PS2_PFX_REL) begin
                        emit       = 1'b1;
                        emit_rel   = 1'b1;
                        state_next = PFX_IDLE;
                    end
                end
                PFX_EXTREL: begin
                    if (bus.byte_data != PS2_PFX_EXT && bus.byte_data != PS2_PFX_REL) begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        emit_rel   = 1'b1;
                        state_next = PFX_IDLE;
                    end
                end
            endcase
        end else if (timed_out) begin
            state_next = PFX_IDLE;
        end
    end

    // Prefix state register; a stale prefix is abandoned after the timeout.
    always_ff @(posedge clk) begin
        if (rst) state <= PFX_IDLE;
        else     state <= state_next;
    end

    // Timeout counter only runs while a prefix waits for its next byte.
    always_ff @(posedge clk) begin
        if (rst || bus.byte_valid || state == PFX_IDLE || timed_out) timer <= '0;
        else                                                        timer <= timer + 1'b1;
    end

    // Sticky overflow: a dropped event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)                   bus.overflow <= 1'b0;
        else if (fifo_dropped)     bus.overflow <= 1'b1;
        else if (bus.clr_overflow) bus.overflow <= 1'b0;
    end

    fifo_sync #(
        .WIDTH (WORD_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (emit),
        .push_data (emit_word),
        .pop       (bus.rd_req),
        .head_data (bus.rd_data),
        .full      (bus.full),
        .empty     (fifo_empty),
        .dropped   (fifo_dropped),
        .count     (bus.count)
    );

    assign bus.rd_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Self-checking bench for ps2_key_event_fifo: directed scenarios plus
// randomized traffic compared every cycle against a queue-based model.
module tb_ps2_key_event_fifo;
    import ps2_key_event_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int PT    = 20;

    logic clk;
    logic rst;
    int   checkCount;
    int   failCount;

    // Reference model: pending prefix flags, idle-cycle count, event queue.
    logic [15:0] modelQ[$];
    bit          mPending;
    bit          mExt;
    bit          mRel;
    int          mIdle;
    bit          mOverflow;

    ps2_key_event_fifo_if #(.DEPTH(DEPTH)) bus ();

    ps2_key_event_fifo #(
        .DEPTH          (DEPTH),
        .PREFIX_TIMEOUT (PT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a runaway simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelStep(input bit bv, input logic [7:0] bd, input bit rq,
                             input bit clr, input bit rs);
        bit          popped;
        bit          emitted;
        bit          drop;
        logic [15:0] word;
        if (rs) begin
            modelQ.delete();
            mPending = 0; mExt = 0; mRel = 0; mIdle = 0; mOverflow = 0;
            return;
        end
        popped  = rq && (modelQ.size() > 0);
        emitted = 0;
        drop    = 0;
        word    = '0;
        if (bv) begin
            mIdle = 0;
            if (bd == 8'hE0) begin
                mPending = 1; mExt = 1;
            end else if (bd == 8'hF0) begin
                mPending = 1; mRel = 1;
            end else begin
                word     = {6'b0, mRel, mExt, bd};
                emitted  = 1;
                mPending = 0; mExt = 0; mRel = 0;
            end
        end else if (mPending) begin
            mIdle++;
            if (mIdle >= PT) begin
                mPending = 0; mExt = 0; mRel = 0; mIdle = 0;
            end
        end
        if (popped) void'(modelQ.pop_front());
        if (emitted) begin
            if (modelQ.size() < DEPTH) modelQ.push_back(word);
            else                       drop = 1;
        end
        if (drop)     mOverflow = 1;
        else if (clr) mOverflow = 0;
    endtask

    task automatic compareAll();
        logic [15:0] headExp;
        headExp = (modelQ.size() > 0) ? modelQ[0] : 16'h0;
        checkOutput("rd_valid", 32'(bus.rd_valid), 32'(modelQ.size() > 0));
        checkOutput("rd_data",  32'(bus.rd_data),  32'(headExp));
        checkOutput("count",    32'(bus.count),    32'(modelQ.size()));
        checkOutput("full",     32'(bus.full),     32'(modelQ.size() == DEPTH));
        checkOutput("overflow", 32'(bus.overflow), 32'(mOverflow));
    endtask

    // One clock cycle: drive while clk low, model at the edge, compare at negedge.
    task automatic applyStimulus(input bit bv, input logic [7:0] bd, input bit rq, input bit clr);
        bus.byte_valid   = bv;
        bus.byte_data    = bd;
        bus.rd_req       = rq;
        bus.clr_overflow = clr;
        @(posedge clk);
        modelStep(bv, bd, rq, clr, rst);
        @(negedge clk);
        compareAll();
    endtask

    task automatic resetDut(input int cycles);
        rst = 1'b1;
        repeat (cycles) applyStimulus(0, 8'h00, 0, 0);
        rst = 1'b0;
    endtask

    task automatic popExpect(input logic [15:0] expected);
        checkOutput("pop_head", 32'(bus.rd_data), 32'(expected));
        applyStimulus(0, 8'h00, 1, 0);
    endtask

    initial begin
        int rdPct;
        int bvPct;
        int sel;
        logic [7:0] b;
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        bus.byte_valid = 0; bus.byte_data = 0; bus.rd_req = 0; bus.clr_overflow = 0;
        @(negedge clk);

        $display("[TB] reset");
        resetDut(2);
        checkOutput("rst_rd_valid", 32'(bus.rd_valid), 0);
        checkOutput("rst_full",     32'(bus.full),     0);
        checkOutput("rst_count",    32'(bus.count),    0);
        checkOutput("rst_overflow", 32'(bus.overflow), 0);
        checkOutput("rst_rd_data",  32'(bus.rd_data),  0);

        $display("[TB] decode");
        applyStimulus(1, 8'h1C, 0, 0);
        applyStimulus(1, 8'hF0, 0, 0); applyStimulus(1, 8'h1C, 0, 0);
        applyStimulus(1, 8'hE0, 0, 0); applyStimulus(1, 8'h75, 0, 0);
        applyStimulus(1, 8'hE0, 0, 0); applyStimulus(1, 8'hF0, 0, 0); applyStimulus(1, 8'h75, 0, 0);
        popExpect(16'h01C); popExpect(16'h21C); popExpect(16'h175); popExpect(16'h375);

        $display("[TB] overflow");
        for (int i = 1; i <= 17; i++) applyStimulus(1, 8'(i), 0, 0);
        checkOutput("ovf_full",     32'(bus.full),     1);
        checkOutput("ovf_count",    32'(bus.count),    16);
        checkOutput("ovf_overflow", 32'(bus.overflow), 1);
        for (int i = 1; i <= 16; i++) popExpect(16'(i));
        checkOutput("ovf_drained", 32'(bus.rd_valid), 0);
        applyStimulus(0, 8'h00, 0, 1);
        checkOutput("ovf_cleared", 32'(bus.overflow), 0);

        $display("[TB] full with simultaneous push and pop");
        for (int i = 1; i <= 16; i++) applyStimulus(1, 8'(i), 0, 0);
        applyStimulus(1, 8'h2A, 1, 0);
        checkOutput("sim_count",    32'(bus.count),    16);
        checkOutput("sim_overflow", 32'(bus.overflow), 0);
        for (int i = 2; i <= 16; i++) popExpect(16'(i));
        popExpect(16'h02A);
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("empty_pop_count", 32'(bus.count), 0);

        $display("[TB] prefix timeout");
        applyStimulus(1, 8'hE0, 0, 0);
        repeat (PT) applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(1, 8'h1C, 0, 0);
        popExpect(16'h01C);
        applyStimulus(1, 8'hE0, 0, 0);
        repeat (PT - 2) applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(1, 8'h1C, 0, 0);
        popExpect(16'h11C);

        $display("[TB] reset mid-prefix");
        applyStimulus(1, 8'h05, 0, 0); applyStimulus(1, 8'h06, 0, 0); applyStimulus(1, 8'h07, 0, 0);
        applyStimulus(1, 8'hF0, 0, 0);
        resetDut(1);
        applyStimulus(1, 8'h1C, 0, 0);
        checkOutput("midrst_count", 32'(bus.count), 1);
        popExpect(16'h01C);

        $display("[TB] randomized traffic");
        for (int phase = 0; phase < 5; phase++) begin
            rdPct = (phase == 1) ? 5 : (phase == 3 ? 80 : 35);
            bvPct = (phase == 4) ? 4 : 55;
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(999) < 3) begin
                    resetDut(1);
                end else begin
                    sel = $urandom_range(99);
                    b   = 8'($urandom);
                    if (sel < 20)      b = 8'hE0;
                    else if (sel < 40) b = 8'hF0;
                    applyStimulus($urandom_range(99) < bvPct, b,
                                  $urandom_range(99) < rdPct, $urandom_range(99) < 5);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
